pc_reg: RTL and testbench



---
 rtl/pc_reg.sv | 34 +++
 tb/tb_pc_reg.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_reg.sv
// Program counter register: captures the next-PC address each clk edge, 1-cycle latency, output straight from the flop.
// Optional PC_STALL_EN adds a stall input that holds the PC; rst always wins over stall.
module pc_reg #(
  parameter int                 width      = 32,
  parameter logic [width-1:0]   RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  input  logic [width-1:0] addr,
  output logic [width-1:0] pc_next
);

`ifdef PC_STALL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_next <= RESET_ADDR;
    end else if (!stall) begin
      pc_next <= addr;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_next <= RESET_ADDR;
    end else begin
      pc_next <= addr;
    end
  end
`endif

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: default-vector and 0x100-vector instances share clk/rst/addr.
module tb_pc_reg;
  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] pc_a;
  logic [31:0] pc_b;
`ifdef PC_STALL_EN
  logic        stall;
`endif

  int total = 0;
  int bad   = 0;

  pc_reg #(.width(32)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
`ifdef PC_STALL_EN
    .stall   (stall),
`endif
    .addr    (addr),
    .pc_next (pc_a)
  );

  pc_reg #(.width(32), .RESET_ADDR(32'h0000_0100)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
`ifdef PC_STALL_EN
    .stall   (stall),
`endif
    .addr    (addr),
    .pc_next (pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seq [4];

  initial begin
    seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC; seq[3] = 32'h10;
    rst  = 1'b1;
    addr = 32'h0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    #2;
    step();
    check("reset_a", pc_a, 32'h0);
    check("reset_b", pc_b, 32'h0000_0100);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = seq[i];
      step();
      check($sformatf("seq%0d", i), pc_a, seq[i]);
    end

    // no combinational path: output must not move before the edge
    addr = 32'h1000_0000;
    #2;
    check("no_comb", pc_a, 32'h10);
    step();
    check("jump", pc_a, 32'h1000_0000);

    rst  = 1'b1;
    addr = 32'hDEAD_BEEF;
    step();
    check("midrst_a", pc_a, 32'h0);
    check("midrst_b", pc_b, 32'h0000_0100);
    step();
    check("rsthold_a", pc_a, 32'h0);

    rst  = 1'b0;
    addr = 32'h2000_0000;
    step();
    check("post_rst0", pc_a, 32'h2000_0000);
    check("post_rst0_b", pc_b, 32'h2000_0000);
    addr = 32'h2000_0004;
    step();
    check("post_rst1", pc_a, 32'h2000_0004);

    addr = 32'hFFFF_FFFF;
    step();
    check("allones_a", pc_a, 32'hFFFF_FFFF);
    check("allones_b", pc_b, 32'hFFFF_FFFF);
    addr = 32'h0000_0003;
    step();
    check("unaligned", pc_a, 32'h0000_0003);

    rst = 1'b1;
    step();
    check("rst_vec_b", pc_b, 32'h0000_0100);

`ifdef PC_STALL_EN
    rst  = 1'b0;
    addr = 32'h8;
    step();
    check("stall_pre", pc_a, 32'h8);
    stall = 1'b1;
    addr  = 32'hC;
    step();
    check("stall_hold0", pc_a, 32'h8);
    step();
    check("stall_hold1", pc_a, 32'h8);
    stall = 1'b0;
    step();
    check("stall_release", pc_a, 32'hC);
    stall = 1'b1;
    rst   = 1'b1;
    step();
    check("rst_over_stall_a", pc_a, 32'h0);
    check("rst_over_stall_b", pc_b, 32'h0000_0100);
    stall = 1'b0;
    rst   = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
